psram_port_arbiter: RTL and testbench

Two-client request arbiter in front of one channel of the PSRAM controller wrapper. It latches single-cycle byte read/write pulses from two clients (A: cartridge bus slave, B: secondary master such as a sound-ROM fetcher) and issues them one at a time with round-robin priority. It holds the byte address stable until read data returns, then routes the data to the owning client. Reads that never complete are bounded by a timeout.

---
 rtl/psram_arb_pkg.sv | 15 +
 rtl/psram_arb_client_latch.sv | 64 ++++++
 rtl/psram_port_arbiter.sv | 176 +++++++++++++++++
 tb/tb_psram_port_arbiter.sv | 395 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/psram_arb_pkg.sv
// Shared definitions for the two-client PSRAM port arbiter.
package psram_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WR_DONE = 2'd1,
        ST_RD_WAIT = 2'd2
    } arb_state_e;

    localparam logic CLI_A = 1'b0;
    localparam logic CLI_B = 1'b1;

    localparam logic [7:0] FORCED_RDATA = 8'hFF;

endpackage

// File: rtl/psram_arb_client_latch.sv
// Per-client pending-request latch: captures op/address/data on a request pulse while idle.
module psram_arb_client_latch
    import psram_arb_pkg::*;
(
    input  logic        clk,
    input  logic        n_reset,
    input  logic        rd_i,
    input  logic        wr_i,
    input  logic [21:0] address_i,
    input  logic [7:0]  wdata_i,
    input  logic        clear_i,
    output logic        busy_o,
    output logic        req_o,
    output logic        wr_o,
    output logic [21:0] address_o,
    output logic [7:0]  wdata_o
);

    logic        pend_q, pend_d;
    logic        wr_q, wr_d;
    logic [21:0] addr_q, addr_d;
    logic [7:0]  data_q, data_d;
    logic        capture;

    assign capture = (rd_i | wr_i) & ~pend_q;

    always_comb begin
        pend_d = pend_q;
        wr_d   = wr_q;
        addr_d = addr_q;
        data_d = data_q;
        if (capture) begin
            pend_d = 1'b1;
            wr_d   = wr_i;
            addr_d = address_i;
            data_d = wdata_i;
        end else if (clear_i) begin
            pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            pend_q <= 1'b0;
            wr_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            pend_q <= pend_d;
            wr_q   <= wr_d;
            addr_q <= addr_d;
            data_q <= data_d;
        end
    end

    // The request being captured this cycle is visible to the arbiter at once,
    // so an idle port can issue in the same cycle busy rises.
    assign busy_o    = pend_q;
    assign req_o     = pend_q | capture;
    assign wr_o      = pend_q ? wr_q   : wr_i;
    assign address_o = pend_q ? addr_q : address_i;
    assign wdata_o   = pend_q ? data_q : wdata_i;

endmodule

// File: rtl/psram_port_arbiter.sv
// Round-robin arbiter issuing byte reads/writes from two clients to one PSRAM wrapper channel.
module psram_port_arbiter
    import psram_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = 63
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic        a_rd,
    input  logic        a_wr,
    input  logic [21:0] a_address,
    input  logic [7:0]  a_wdata,
    output logic        a_busy,
    output logic [7:0]  a_rdata,
    output logic        a_rdata_en,
    input  logic        b_rd,
    input  logic        b_wr,
    input  logic [21:0] b_address,
    input  logic [7:0]  b_wdata,
    output logic        b_busy,
    output logic [7:0]  b_rdata,
    output logic        b_rdata_en,
    output logic        p_rd,
    output logic        p_wr,
    output logic [21:0] p_address,
    output logic [7:0]  p_wdata,
    input  logic        p_busy,
    input  logic [7:0]  p_rdata,
    input  logic        p_rdata_en,
    output logic        timeout_err
);

    localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT);

    logic        req_a, req_b, wr_a, wr_b, clr_a, clr_b;
    logic [21:0] addr_a, addr_b;
    logic [7:0]  data_a, data_b;

    psram_arb_client_latch u_latch_a (
        .clk(clk), .n_reset(n_reset), .rd_i(a_rd), .wr_i(a_wr),
        .address_i(a_address), .wdata_i(a_wdata), .clear_i(clr_a),
        .busy_o(a_busy), .req_o(req_a), .wr_o(wr_a),
        .address_o(addr_a), .wdata_o(data_a)
    );

    psram_arb_client_latch u_latch_b (
        .clk(clk), .n_reset(n_reset), .rd_i(b_rd), .wr_i(b_wr),
        .address_i(b_address), .wdata_i(b_wdata), .clear_i(clr_b),
        .busy_o(b_busy), .req_o(req_b), .wr_o(wr_b),
        .address_o(addr_b), .wdata_o(data_b)
    );

    arb_state_e  state_q, state_d;
    logic        last_q, last_d, owner_q, owner_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        p_rd_q, p_rd_d, p_wr_q, p_wr_d;
    logic [21:0] p_addr_q, p_addr_d;
    logic [7:0]  p_wdata_q, p_wdata_d;
    logic [7:0]  a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
    logic        a_en_q, a_en_d, b_en_q, b_en_d, tmo_q, tmo_d;
    logic        sel, done;
    logic [7:0]  done_data;

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        owner_d   = owner_q;
        cnt_d     = cnt_q;
        p_rd_d    = 1'b0;
        p_wr_d    = 1'b0;
        p_addr_d  = p_addr_q;
        p_wdata_d = p_wdata_q;
        a_rdata_d = a_rdata_q;
        b_rdata_d = b_rdata_q;
        a_en_d    = 1'b0;
        b_en_d    = 1'b0;
        tmo_d     = 1'b0;
        clr_a     = 1'b0;
        clr_b     = 1'b0;
        done      = 1'b0;
        done_data = p_rdata;
        sel       = (req_a && req_b) ? ~last_q : (req_a ? CLI_A : CLI_B);

        unique case (state_q)
            ST_IDLE: begin
                if (!p_busy && (req_a || req_b)) begin
                    owner_d   = sel;
                    last_d    = sel;
                    p_addr_d  = (sel == CLI_A) ? addr_a : addr_b;
                    p_wdata_d = (sel == CLI_A) ? data_a : data_b;
                    cnt_d     = '0;
                    if ((sel == CLI_A) ? wr_a : wr_b) begin
                        p_wr_d  = 1'b1;
                        state_d = ST_WR_DONE;
                    end else begin
                        p_rd_d  = 1'b1;
                        state_d = ST_RD_WAIT;
                    end
                end
            end
            ST_WR_DONE: begin
                clr_a   = (owner_q == CLI_A);
                clr_b   = (owner_q == CLI_B);
                state_d = ST_IDLE;
            end
            ST_RD_WAIT: begin
                // cnt_q == 0 is the p_rd cycle, where p_rdata_en may still be stale.
                if (cnt_q != '0 && p_rdata_en) begin
                    done = 1'b1;
                end else if (cnt_q == TMO_LIMIT) begin
                    done      = 1'b1;
                    done_data = FORCED_RDATA;
                    tmo_d     = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
                if (done) begin
                    state_d = ST_IDLE;
                    if (owner_q == CLI_A) begin
                        a_rdata_d = done_data;
                        a_en_d    = 1'b1;
                        clr_a     = 1'b1;
                    end else begin
                        b_rdata_d = done_data;
                        b_en_d    = 1'b1;
                        clr_b     = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q   <= ST_IDLE;
            last_q    <= CLI_B;
            owner_q   <= CLI_A;
            cnt_q     <= '0;
            p_rd_q    <= 1'b0;
            p_wr_q    <= 1'b0;
            p_addr_q  <= '0;
            p_wdata_q <= '0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
            a_en_q    <= 1'b0;
            b_en_q    <= 1'b0;
            tmo_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            owner_q   <= owner_d;
            cnt_q     <= cnt_d;
            p_rd_q    <= p_rd_d;
            p_wr_q    <= p_wr_d;
            p_addr_q  <= p_addr_d;
            p_wdata_q <= p_wdata_d;
            a_rdata_q <= a_rdata_d;
            b_rdata_q <= b_rdata_d;
            a_en_q    <= a_en_d;
            b_en_q    <= b_en_d;
            tmo_q     <= tmo_d;
        end
    end

    assign p_rd        = p_rd_q;
    assign p_wr        = p_wr_q;
    assign p_address   = p_addr_q;
    assign p_wdata     = p_wdata_q;
    assign a_rdata     = a_rdata_q;
    assign b_rdata     = b_rdata_q;
    assign a_rdata_en  = a_en_q;
    assign b_rdata_en  = b_en_q;
    assign timeout_err = tmo_q;

endmodule

// File: tb/tb_psram_port_arbiter.sv
// Self-checking bench for psram_port_arbiter: directed scenarios plus a randomized scoreboard run.
module tb_psram_port_arbiter;

    localparam int unsigned TIMEOUT = 63;

    logic        clk = 1'b0;
    logic        n_reset;
    logic        a_rd, a_wr, b_rd, b_wr;
    logic [21:0] a_address, b_address;
    logic [7:0]  a_wdata, b_wdata;
    logic        a_busy, b_busy, a_rdata_en, b_rdata_en;
    logic [7:0]  a_rdata, b_rdata;
    logic        p_rd, p_wr, p_busy, p_rdata_en, timeout_err;
    logic [21:0] p_address;
    logic [7:0]  p_wdata, p_rdata;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    psram_port_arbiter #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .n_reset(n_reset),
        .a_rd(a_rd), .a_wr(a_wr), .a_address(a_address), .a_wdata(a_wdata),
        .a_busy(a_busy), .a_rdata(a_rdata), .a_rdata_en(a_rdata_en),
        .b_rd(b_rd), .b_wr(b_wr), .b_address(b_address), .b_wdata(b_wdata),
        .b_busy(b_busy), .b_rdata(b_rdata), .b_rdata_en(b_rdata_en),
        .p_rd(p_rd), .p_wr(p_wr), .p_address(p_address), .p_wdata(p_wdata),
        .p_busy(p_busy), .p_rdata(p_rdata), .p_rdata_en(p_rdata_en),
        .timeout_err(timeout_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        a_rd = 0; a_wr = 0; a_address = '0; a_wdata = '0;
        b_rd = 0; b_wr = 0; b_address = '0; b_wdata = '0;
    endtask

    task automatic test_reset();
        n_reset = 0; idle_inputs(); p_busy = 1; p_rdata = '0; p_rdata_en = 0;
        repeat (3) step();
        checks++;
        if ({a_busy, b_busy, a_rdata_en, b_rdata_en, p_rd, p_wr, timeout_err} !== 7'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=%b",
                     {a_busy, b_busy, a_rdata_en, b_rdata_en, p_rd, p_wr, timeout_err}, 7'b0);
        end
        checks++;
        if ({a_rdata, b_rdata, p_wdata} !== 24'h0) begin
            failures++;
            $display("FAIL reset_data got=%h exp=%h", {a_rdata, b_rdata, p_wdata}, 24'h0);
        end
        checks++;
        if (p_address !== 22'h0) begin
            failures++;
            $display("FAIL reset_addr got=%h exp=%h", p_address, 22'h0);
        end
        n_reset = 1;
    endtask

    task automatic test_busy_hold();
        bit saw = 0;
        step();
        a_rd = 1; a_address = 22'h000005;
        step();
        a_rd = 0;
        checks++;
        if (a_busy !== 1'b1) begin failures++; $display("FAIL hold_busy got=%b exp=1", a_busy); end
        repeat (18) begin
            step();
            if (p_rd !== 1'b0 || p_wr !== 1'b0) saw = 1;
        end
        checks++;
        if (saw) begin failures++; $display("FAIL hold_no_cmd got=1 exp=0"); end
        p_busy = 0;
        step();
        checks++;
        if (p_rd !== 1'b1 || p_wr !== 1'b0 || p_address !== 22'h000005) begin
            failures++;
            $display("FAIL hold_issue got rd=%b wr=%b addr=%h exp rd=1 wr=0 addr=000005", p_rd, p_wr, p_address);
        end
    endtask

    task automatic test_read_return();
        int aen = 0;
        bit bseen = 0;
        for (int k = 1; k <= 3; k++) begin
            step();
            aen += int'(a_rdata_en); bseen |= b_rdata_en;
            if (k == 1) begin
                checks++;
                if (p_rd !== 1'b0) begin failures++; $display("FAIL read_prd_pulse got=%b exp=0", p_rd); end
            end
        end
        step();
        p_rdata = 8'h5A; p_rdata_en = 1;
        aen += int'(a_rdata_en); bseen |= b_rdata_en;
        step();
        checks++;
        if (a_rdata_en !== 1'b1 || a_rdata !== 8'h5A || a_busy !== 1'b0) begin
            failures++;
            $display("FAIL read_data got en=%b data=%h busy=%b exp en=1 data=5a busy=0", a_rdata_en, a_rdata, a_busy);
        end
        aen += int'(a_rdata_en); bseen |= b_rdata_en;
        repeat (4) begin step(); aen += int'(a_rdata_en); bseen |= b_rdata_en; end
        checks++;
        if (aen != 1 || bseen) begin
            failures++;
            $display("FAIL read_once got a_pulses=%0d b_seen=%b exp a_pulses=1 b_seen=0", aen, bseen);
        end
    endtask

    task automatic test_stale();
        b_rd = 1; b_address = 22'h1234AB;
        step();
        b_rd = 0;
        checks++;
        if (p_rd !== 1'b1 || p_address !== 22'h1234AB) begin
            failures++;
            $display("FAIL stale_issue got rd=%b addr=%h exp rd=1 addr=1234ab", p_rd, p_address);
        end
        step();
        p_rdata_en = 0;
        checks++;
        if (b_rdata_en !== 1'b0) begin failures++; $display("FAIL stale_ignored got=%b exp=0", b_rdata_en); end
        step();
        step();
        p_rdata = 8'hC3; p_rdata_en = 1;
        checks++;
        if (b_rdata_en !== 1'b0) begin failures++; $display("FAIL stale_early got=%b exp=0", b_rdata_en); end
        step();
        checks++;
        if (b_rdata_en !== 1'b1 || b_rdata !== 8'hC3 || a_rdata_en !== 1'b0) begin
            failures++;
            $display("FAIL stale_fresh got en=%b data=%h a_en=%b exp en=1 data=c3 a_en=0", b_rdata_en, b_rdata, a_rdata_en);
        end
    endtask

    task automatic test_round_robin();
        bit saw = 0;
        step();
        a_wr = 1; a_address = 22'h000100; a_wdata = 8'h11;
        b_wr = 1; b_rd = 1; b_address = 22'h000200; b_wdata = 8'h22;
        step();
        a_wr = 0; b_wr = 0; b_rd = 0;
        checks++;
        if (p_wr !== 1'b1 || p_rd !== 1'b0 || p_address !== 22'h000100 || p_wdata !== 8'h11) begin
            failures++;
            $display("FAIL rr_first got wr=%b rd=%b addr=%h data=%h exp wr=1 rd=0 addr=000100 data=11", p_wr, p_rd, p_address, p_wdata);
        end
        p_busy = 1;
        step();
        saw |= p_rd | p_wr;
        step();
        saw |= p_rd | p_wr;
        checks++;
        if (a_busy !== 1'b0 || b_busy !== 1'b1) begin
            failures++;
            $display("FAIL rr_wr_busy got a=%b b=%b exp a=0 b=1", a_busy, b_busy);
        end
        a_wr = 1; a_address = 22'h000101; a_wdata = 8'h33;
        step();
        a_wr = 0; p_busy = 0;
        saw |= p_rd | p_wr;
        step();
        checks++;
        if (saw || p_wr !== 1'b1 || p_address !== 22'h000200 || p_wdata !== 8'h22) begin
            failures++;
            $display("FAIL rr_second got early=%b wr=%b addr=%h data=%h exp early=0 wr=1 addr=000200 data=22", saw, p_wr, p_address, p_wdata);
        end
        p_busy = 1; saw = 0;
        repeat (3) begin step(); saw |= p_rd | p_wr; end
        p_busy = 0;
        step();
        checks++;
        if (saw || p_wr !== 1'b1 || p_address !== 22'h000101 || p_wdata !== 8'h33) begin
            failures++;
            $display("FAIL rr_third got early=%b wr=%b addr=%h data=%h exp early=0 wr=1 addr=000101 data=33", saw, p_wr, p_address, p_wdata);
        end
        step();
        step();
        checks++;
        if (a_busy !== 1'b0 || b_busy !== 1'b0) begin
            failures++;
            $display("FAIL rr_idle got a=%b b=%b exp a=0 b=0", a_busy, b_busy);
        end
    endtask

    task automatic test_timeout();
        bit early = 0;
        p_rdata_en = 0;
        a_rd = 1; a_address = 22'h3FFFFF;
        step();
        a_rd = 0;
        checks++;
        if (p_rd !== 1'b1) begin failures++; $display("FAIL tmo_issue got=%b exp=1", p_rd); end
        for (int k = 1; k <= int'(TIMEOUT); k++) begin
            step();
            if (a_rdata_en || timeout_err || !a_busy) early = 1;
        end
        checks++;
        if (early) begin failures++; $display("FAIL tmo_early got=1 exp=0"); end
        step();
        checks++;
        if (a_rdata_en !== 1'b1 || a_rdata !== 8'hFF || timeout_err !== 1'b1 || a_busy !== 1'b0 || b_rdata_en !== 1'b0) begin
            failures++;
            $display("FAIL tmo_fire got en=%b data=%h err=%b busy=%b b_en=%b exp en=1 data=ff err=1 busy=0 b_en=0",
                     a_rdata_en, a_rdata, timeout_err, a_busy, b_rdata_en);
        end
        step();
        checks++;
        if (timeout_err !== 1'b0 || a_rdata_en !== 1'b0) begin
            failures++;
            $display("FAIL tmo_pulse got err=%b en=%b exp err=0 en=0", timeout_err, a_rdata_en);
        end
    endtask

    task automatic test_reset_mid_read();
        bit seen = 0;
        p_rdata_en = 0;
        b_rd = 1; b_address = 22'h0ABCDE;
        step();
        b_rd = 0;
        checks++;
        if (p_rd !== 1'b1) begin failures++; $display("FAIL mid_issue got=%b exp=1", p_rd); end
        step();
        step();
        #2 n_reset = 0;
        #1;
        checks++;
        if ({a_busy, b_busy, a_rdata_en, b_rdata_en, p_rd, p_wr, timeout_err} !== 7'b0
            || p_address !== 22'h0 || {a_rdata, b_rdata, p_wdata} !== 24'h0) begin
            failures++;
            $display("FAIL mid_reset got flags=%b addr=%h data=%h exp flags=0 addr=0 data=0",
                     {a_busy, b_busy, a_rdata_en, b_rdata_en, p_rd, p_wr, timeout_err}, p_address, {a_rdata, b_rdata, p_wdata});
        end
        step();
        step();
        n_reset = 1; p_rdata = 8'h77; p_rdata_en = 1;
        repeat (10) begin step(); seen |= a_rdata_en | b_rdata_en | timeout_err | b_busy; end
        checks++;
        if (seen) begin failures++; $display("FAIL mid_abandon got=1 exp=0"); end
    endtask

    task automatic test_random(input int n_cycles);
        bit pend[2], issued[2], isw[2];
        logic [21:0] raddr[2];
        logic [7:0]  rdat[2];
        int acc_cyc[2], wr_cyc[2];
        logic [7:0] ref_mem[16];
        logic [7:0] dev_mem[16];
        bit last, rd_act, prev_busy, ea, eb, exp_en, got_en, got_busy;
        int rd_owner, rd_issue, data_cyc, exp_cyc, busy_left, cyc, o, sel;
        logic [7:0]  exp_val, got_d, dat_v;
        logic [21:0] adr_v;
        logic rd_v, wr_v;

        for (int i = 0; i < 16; i++) begin
            ref_mem[i] = 8'(i * 37 + 11);
            dev_mem[i] = ref_mem[i];
        end
        for (int i = 0; i < 2; i++) begin
            pend[i] = 0; issued[i] = 0; isw[i] = 0; raddr[i] = '0; rdat[i] = '0;
            acc_cyc[i] = 0; wr_cyc[i] = -10;
        end
        last = 1; rd_act = 0; rd_owner = 0; rd_issue = -10; data_cyc = -10; exp_cyc = -10;
        exp_val = '0; busy_left = 0; cyc = 0; p_busy = 0; prev_busy = 0;
        idle_inputs();

        for (int t = 0; t < n_cycles + 80; t++) begin
            step();
            cyc++;
            for (int i = 0; i < 2; i++)
                if (pend[i] && isw[i] && issued[i] && cyc >= wr_cyc[i] + 2) pend[i] = 0;

            if (p_rd || p_wr) begin
                ea = pend[0] && !issued[0];
                eb = pend[1] && !issued[1];
                checks++;
                if (!(ea || eb) || prev_busy || (p_rd && p_wr)) begin
                    failures++;
                    $display("FAIL rand_cmd_legal cyc=%0d got rd=%b wr=%b busy_prev=%b exp eligible request", cyc, p_rd, p_wr, prev_busy);
                end else begin
                    o = (ea && eb) ? (last ? 0 : 1) : (ea ? 0 : 1);
                    checks++;
                    if (p_wr !== isw[o] || p_address !== raddr[o] || (isw[o] && p_wdata !== rdat[o])) begin
                        failures++;
                        $display("FAIL rand_cmd cyc=%0d got wr=%b addr=%h data=%h exp client=%0d wr=%b addr=%h data=%h",
                                 cyc, p_wr, p_address, p_wdata, o, isw[o], raddr[o], rdat[o]);
                    end
                    issued[o] = 1;
                    last = (o == 1);
                    if (isw[o]) begin
                        ref_mem[raddr[o][3:0]] = rdat[o];
                        wr_cyc[o] = cyc;
                    end else begin
                        rd_act = 1; rd_owner = o; rd_issue = cyc;
                        data_cyc = cyc + 2 + int'($urandom_range(4, 0));
                        exp_cyc = data_cyc + 1;
                        exp_val = ref_mem[raddr[o][3:0]];
                    end
                end
                if (p_wr) dev_mem[p_address[3:0]] = p_wdata;
                busy_left = int'($urandom_range(3, 0));
            end

            for (int i = 0; i < 2; i++) begin
                exp_en = rd_act && rd_owner == i && cyc == exp_cyc;
                got_en = (i == 0) ? a_rdata_en : b_rdata_en;
                got_d  = (i == 0) ? a_rdata : b_rdata;
                checks++;
                if (got_en !== exp_en) begin
                    failures++;
                    $display("FAIL rand_rdata_en client=%0d cyc=%0d got=%b exp=%b", i, cyc, got_en, exp_en);
                end
                if (exp_en) begin
                    checks++;
                    if (got_d !== exp_val) begin
                        failures++;
                        $display("FAIL rand_rdata client=%0d cyc=%0d got=%h exp=%h", i, cyc, got_d, exp_val);
                    end
                end
            end
            if (rd_act && cyc == exp_cyc) begin pend[rd_owner] = 0; rd_act = 0; end
            checks++;
            if (timeout_err !== 1'b0) begin failures++; $display("FAIL rand_timeout cyc=%0d got=%b exp=0", cyc, timeout_err); end

            for (int i = 0; i < 2; i++) begin
                got_busy = (i == 0) ? a_busy : b_busy;
                if (!(isw[i] && issued[i] && cyc == wr_cyc[i] + 1)) begin
                    checks++;
                    if (got_busy !== pend[i]) begin
                        failures++;
                        $display("FAIL rand_busy client=%0d cyc=%0d got=%b exp=%b", i, cyc, got_busy, pend[i]);
                    end
                end
                if (pend[i] && !issued[i] && cyc - acc_cyc[i] > 40) begin
                    checks++; failures++;
                    $display("FAIL rand_starve client=%0d cyc=%0d got=not issued exp=issued within 40", i, cyc);
                    pend[i] = 0;
                end
            end

            p_busy = (busy_left > 0);
            if (busy_left > 0) busy_left--;
            prev_busy = p_busy;
            if (rd_act && cyc == rd_issue + 1) p_rdata_en = 0;
            if (rd_act && cyc == data_cyc) begin p_rdata = dev_mem[p_address[3:0]]; p_rdata_en = 1; end

            for (int i = 0; i < 2; i++) begin
                rd_v = 0; wr_v = 0;
                adr_v = {($urandom_range(1, 0) == 1) ? 18'h2AAAA : 18'h0, 4'($urandom_range(15, 0))};
                dat_v = 8'($urandom);
                if (t < n_cycles && !pend[i] && $urandom_range(2, 0) == 0) begin
                    sel = int'($urandom_range(2, 0));
                    rd_v = (sel != 1); wr_v = (sel != 0);
                    pend[i] = 1; issued[i] = 0; isw[i] = wr_v; raddr[i] = adr_v; rdat[i] = dat_v; acc_cyc[i] = cyc;
                end else if (pend[i] && !(isw[i] && issued[i]) && $urandom_range(5, 0) == 0) begin
                    rd_v = 1'($urandom_range(1, 0)); wr_v = ~rd_v;
                end
                if (i == 0) begin a_rd = rd_v; a_wr = wr_v; a_address = adr_v; a_wdata = dat_v; end
                else        begin b_rd = rd_v; b_wr = wr_v; b_address = adr_v; b_wdata = dat_v; end
            end
        end
        checks++;
        if (pend[0] || pend[1]) begin
            failures++;
            $display("FAIL rand_drain got pending=%b%b exp=00", pend[0], pend[1]);
        end
    endtask

    initial begin
        test_reset();
        test_busy_hold();
        test_read_return();
        test_stale();
        test_round_robin();
        test_timeout();
        test_reset_mid_read();
        test_random(1500);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=time limit exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
